cpu_memif: RTL

Memory-access stage bridging the P3 execute stage and the P4 exception stage. It computes the effective address, checks alignment and user-mode region permissions from `csr_dmpu0..7`, and drives a single-outstanding request/ack data bus. It registers `p4_misaligned_address`, `p4_load_access_fault`, `p4_store_access_fault` and `p4_mem_addr` for the exception stage, and generates the pipeline `stall`.

---
 rtl/cpu_memif_pkg.sv | 43 ++++
 rtl/cpu_memif_if.sv | 20 ++
 rtl/cpu_memif_dmpu_check.sv | 33 +++
 rtl/cpu_memif.sv | 136 +++++++++++++
 4 files changed

// File: rtl/cpu_memif_pkg.sv
// Shared definitions for the memory-access stage: opcodes, DMPU descriptor
// layout and the registered data-bus request record.
package cpu_memif_pkg;

  localparam logic [5:0] OP_LDB = 6'h10;
  localparam logic [5:0] OP_LDH = 6'h11;
  localparam logic [5:0] OP_LDW = 6'h12;
  localparam logic [5:0] OP_STB = 6'h18;
  localparam logic [5:0] OP_STH = 6'h19;
  localparam logic [5:0] OP_STW = 6'h1A;

  localparam int unsigned DMPU_EN    = 7;
  localparam int unsigned DMPU_W     = 6;
  localparam int unsigned DMPU_R     = 5;
  localparam int unsigned DMPU_K     = 0;
  localparam int unsigned DMPU_K_W   = 5;
  localparam int unsigned DMPU_MIN_K = 12;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_e;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } memif_state_e;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [1:0]  off;
    mem_size_e   size;
  } dbus_req_t;

  function automatic logic is_mem_op(input logic [5:0] op);
    return op inside {OP_LDB, OP_LDH, OP_LDW, OP_STB, OP_STH, OP_STW};
  endfunction

endpackage

// File: rtl/cpu_memif_if.sv
// Single-outstanding request/ack data bus between the memory stage and memory.
interface cpu_memif_if;
  logic        dbus_request;
  logic        dbus_write;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic [3:0]  dbus_wmask;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;

  modport master (
    output dbus_request, dbus_write, dbus_addr, dbus_wdata, dbus_wmask,
    input  dbus_ack, dbus_rdata
  );

  modport slave (
    input  dbus_request, dbus_write, dbus_addr, dbus_wdata, dbus_wmask,
    output dbus_ack, dbus_rdata
  );
endinterface

// File: rtl/cpu_memif_dmpu_check.sv
// User-mode region permission check against the DMPU descriptors.
module cpu_dmpu_check
  import cpu_memif_pkg::*;
#(
  parameter int unsigned NUM_REGIONS = 8
) (
  input  logic [31:0] ea,
  input  logic        is_store,
  input  logic        supervisor,
  input  logic [31:0] csr_dmpu [NUM_REGIONS],
  output logic        allow
);

  // Region of 2^k bytes: compare only the address bits above k.
  function automatic logic region_grants(input logic [31:0] d, input logic [31:0] a,
                                         input logic st);
    logic [4:0]  k;
    logic [31:0] mask;
    logic        hit;
    k    = d[DMPU_K +: DMPU_K_W];
    mask = 32'hFFFF_FFFF << k;
    hit  = d[DMPU_EN] && (32'(k) >= DMPU_MIN_K) && (((a ^ d) & mask) == '0);
    return hit && (st ? d[DMPU_W] : d[DMPU_R]);
  endfunction

  always_comb begin
    allow = supervisor;
    for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
      if (region_grants(csr_dmpu[i], ea, is_store)) allow = 1'b1;
    end
  end

endmodule

// File: rtl/cpu_memif.sv
// Memory-access stage: effective address, alignment/permission checks,
// data-bus request FSM, store lane steering and load extension.
module cpu_memif
  import cpu_memif_pkg::*;
#(
  parameter int unsigned NUM_REGIONS = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  p3_op,
  input  logic [31:0] p3_data_a,
  input  logic [12:0] p3_literal,
  input  logic [31:0] p3_data_b,
  input  logic        p4_jump_taken,
  input  logic [31:0] csr_dmpu0,
  input  logic [31:0] csr_dmpu1,
  input  logic [31:0] csr_dmpu2,
  input  logic [31:0] csr_dmpu3,
  input  logic [31:0] csr_dmpu4,
  input  logic [31:0] csr_dmpu5,
  input  logic [31:0] csr_dmpu6,
  input  logic [31:0] csr_dmpu7,
  input  logic        supervisor,
  output logic        stall,
  output logic [31:0] p4_mem_addr,
  output logic        p4_misaligned_address,
  output logic        p4_load_access_fault,
  output logic        p4_store_access_fault,
  output logic [31:0] p4_load_data,
  cpu_memif_if.master dbus
);

  logic [31:0]  csr_dmpu [NUM_REGIONS];
  logic [31:0]  ea;
  mem_size_e    size;
  logic         is_store, active, misaligned, allow, legal;
  logic         fault_mis, fault_acc;
  logic [31:0]  lane;
  dbus_req_t    req_n, req_q;
  memif_state_e state;

  always_comb csr_dmpu = '{csr_dmpu0, csr_dmpu1, csr_dmpu2, csr_dmpu3,
                           csr_dmpu4, csr_dmpu5, csr_dmpu6, csr_dmpu7};

  assign ea         = p3_data_a + {{19{p3_literal[12]}}, p3_literal};
  assign size       = mem_size_e'(p3_op[1:0]);
  assign is_store   = p3_op[3];
  assign active     = is_mem_op(p3_op) & ~p4_jump_taken;
  assign misaligned = ((size == SZ_HALF) & ea[0]) | ((size == SZ_WORD) & (|ea[1:0]));
  assign fault_mis  = active & misaligned;
  assign fault_acc  = active & ~misaligned & ~allow;
  assign legal      = active & ~misaligned & allow;

  cpu_dmpu_check #(.NUM_REGIONS(NUM_REGIONS)) u_dmpu_check (
    .ea        (ea),
    .is_store  (is_store),
    .supervisor(supervisor),
    .csr_dmpu  (csr_dmpu),
    .allow     (allow)
  );

  always_comb begin
    req_n       = '0;
    req_n.write = is_store;
    req_n.addr  = {ea[31:2], 2'b00};
    req_n.off   = ea[1:0];
    req_n.size  = size;
    case (size)
      SZ_BYTE: begin
        req_n.wdata = {4{p3_data_b[7:0]}};
        req_n.wmask = 4'b0001 << ea[1:0];
      end
      SZ_HALF: begin
        req_n.wdata = {2{p3_data_b[15:0]}};
        req_n.wmask = ea[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        req_n.wdata = p3_data_b;
        req_n.wmask = 4'b1111;
      end
    endcase
    if (!is_store) req_n.wmask = '0;
  end

  assign dbus.dbus_request = (state == ST_BUSY);
  assign dbus.dbus_write   = req_q.write;
  assign dbus.dbus_addr    = req_q.addr;
  assign dbus.dbus_wdata   = req_q.wdata;
  assign dbus.dbus_wmask   = req_q.wmask;
  assign stall             = dbus.dbus_request & ~dbus.dbus_ack;

  // Lane offset and size come from the request in flight, not from P3.
  assign lane = dbus.dbus_rdata >> {req_q.off, 3'b000};

  always_comb begin
    case (req_q.size)
      SZ_BYTE: p4_load_data = {{24{lane[7]}}, lane[7:0]};
      SZ_HALF: p4_load_data = {{16{lane[15]}}, lane[15:0]};
      default: p4_load_data = lane;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state                 <= ST_IDLE;
      req_q                 <= '0;
      p4_mem_addr           <= '0;
      p4_misaligned_address <= 1'b0;
      p4_load_access_fault  <= 1'b0;
      p4_store_access_fault <= 1'b0;
    end else begin
      if (!stall) begin
        p4_mem_addr           <= ea;
        p4_misaligned_address <= fault_mis;
        p4_load_access_fault  <= fault_acc & ~is_store;
        p4_store_access_fault <= fault_acc & is_store;
      end
      unique case (state)
        ST_IDLE: begin
          if (legal) begin
            state <= ST_BUSY;
            req_q <= req_n;
          end
        end
        ST_BUSY: begin
          if (dbus.dbus_ack) begin
            if (legal) req_q <= req_n;
            else       state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
